// File: rtl/crypto_out_stats.sv
`default_nettype none
`timescale 1ns/1ps
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif
// ---------------------------------------------------------------------------
// crypto_out_stats: buffers the crypto output stream, counts packets/words,
// tracks the longest packet and exposes stats on the UDP register chain. Rev 1.0
// ---------------------------------------------------------------------------
module crypto_out_stats #(
   parameter int DATA_WIDTH        = 64,
   parameter int CTRL_WIDTH        = DATA_WIDTH/8,
   parameter int UDP_REG_SRC_WIDTH = 2,
   parameter int FIFO_DEPTH_BITS   = 2,
   parameter logic [`UDP_REG_ADDR_WIDTH-3:0] BLOCK_TAG = 21'h1A0000
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [DATA_WIDTH-1:0]           in_data,
   input  logic [CTRL_WIDTH-1:0]           in_ctrl,
   input  logic                            in_wr,
   output logic                            in_rdy,
   output logic [DATA_WIDTH-1:0]           out_data,
   output logic [CTRL_WIDTH-1:0]           out_ctrl,
   output logic                            out_wr,
   input  logic                            out_rdy,
   input  logic                            reg_req_in,
   input  logic                            reg_ack_in,
   input  logic                            reg_rd_wr_L_in,
   input  logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
   input  logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
   input  logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_in,
   output logic                            reg_req_out,
   output logic                            reg_ack_out,
   output logic                            reg_rd_wr_L_out,
   output logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
   output logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
   output logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_out
);

   localparam int ADDR_W = `UDP_REG_ADDR_WIDTH;
   localparam int REG_W  = `CPCI_NF2_DATA_WIDTH;
   localparam int DEPTH  = 1 << FIFO_DEPTH_BITS;
   localparam int WORD_W = DATA_WIDTH + CTRL_WIDTH;

   typedef enum logic [0:0] {S_HDR = 1'b0, S_PAYLOAD = 1'b1} state_t;

   logic [WORD_W-1:0]          mem [DEPTH];
   logic [FIFO_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
   logic [FIFO_DEPTH_BITS:0]   count, count_nxt;
   logic                       rdy_q;
   logic                       do_wr, do_rd;
   logic [WORD_W-1:0]          rd_word;
   logic [CTRL_WIDTH-1:0]      rd_ctrl;

   state_t                     state, state_nxt;
   logic                       eop;
   logic [REG_W-1:0]           cur_len, len_inc;
   logic [REG_W-1:0]           pkt_cnt, word_cnt, max_len;
   logic                       enable;

   logic                       addr_match, wr_hit, clear_cmd, ctrl_wr;
   logic [REG_W-1:0]           rd_val;

   assign do_wr   = in_wr && rdy_q;
   assign do_rd   = (count != '0) && out_rdy;
   assign rd_word = mem[rd_ptr];
   assign rd_ctrl = rd_word[WORD_W-1:DATA_WIDTH];

   assign in_rdy   = rdy_q;
   assign out_wr   = do_rd;
   assign out_data = do_rd ? rd_word[DATA_WIDTH-1:0] : '0;
   assign out_ctrl = do_rd ? rd_ctrl : '0;

   always_comb begin
      count_nxt = count;
      if (do_wr && !do_rd)
         count_nxt = count + 1'b1;
      else if (!do_wr && do_rd)
         count_nxt = count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (do_wr)
         mem[wr_ptr] <= {in_ctrl, in_data};
   end

   // count never exceeds DEPTH, so its MSB alone flags "full"
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rdy_q  <= 1'b0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         rdy_q <= ~count_nxt[FIFO_DEPTH_BITS];
      end
   end

   always_comb begin
      state_nxt = state;
      eop       = 1'b0;
      if (do_rd) begin
         case (state)
            S_HDR:     if (rd_ctrl == '0) state_nxt = S_PAYLOAD;
            S_PAYLOAD: if (rd_ctrl != '0) begin
                          eop       = 1'b1;
                          state_nxt = S_HDR;
                       end
            default:   state_nxt = S_HDR;
         endcase
      end
   end

   assign len_inc = cur_len + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_HDR;
         cur_len <= '0;
      end else begin
         state <= state_nxt;
         if (do_rd)
            cur_len <= eop ? '0 : len_inc;
      end
   end

   assign addr_match = reg_req_in && !reg_ack_in &&
                       (reg_addr_in[ADDR_W-1:2] == BLOCK_TAG);
   assign wr_hit     = addr_match && !reg_rd_wr_L_in;
   assign ctrl_wr    = wr_hit && (reg_addr_in[1:0] == 2'd0);
   // a CTRL write with the clear bit set is a pure command; enable is kept
   assign clear_cmd  = ctrl_wr && reg_data_in[1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         enable   <= 1'b1;
         pkt_cnt  <= '0;
         word_cnt <= '0;
         max_len  <= '0;
      end else begin
         if (ctrl_wr && !reg_data_in[1])
            enable <= reg_data_in[0];
         if (clear_cmd) begin
            pkt_cnt  <= '0;
            word_cnt <= '0;
            max_len  <= '0;
         end else if (enable) begin
            if (do_rd) word_cnt <= word_cnt + 1'b1;
            if (eop) begin
               pkt_cnt <= pkt_cnt + 1'b1;
               if (len_inc > max_len) max_len <= len_inc;
            end
         end
      end
   end

   always_comb begin
      rd_val = '0;
      case (reg_addr_in[1:0])
         2'd0:    rd_val[0] = enable;
         2'd1:    rd_val    = pkt_cnt;
         2'd2:    rd_val    = word_cnt;
         default: rd_val    = max_len;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         reg_req_out     <= 1'b0;
         reg_ack_out     <= 1'b0;
         reg_rd_wr_L_out <= 1'b0;
         reg_addr_out    <= '0;
         reg_data_out    <= '0;
         reg_src_out     <= '0;
      end else begin
         reg_req_out     <= reg_req_in;
         reg_ack_out     <= reg_ack_in || addr_match;
         reg_rd_wr_L_out <= reg_rd_wr_L_in;
         reg_addr_out    <= reg_addr_in;
         reg_src_out     <= reg_src_in;
         reg_data_out    <= (addr_match && reg_rd_wr_L_in) ? rd_val : reg_data_in;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_crypto_out_stats.sv
`default_nettype none
`timescale 1ns/1ps
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif
// Scoreboard bench for crypto_out_stats: stream words and register responses
// are queued at issue time and checked by independent monitors.
module tb_crypto_out_stats;
   localparam int DW = 64;
   localparam int CW = 8;
   localparam int SW = 2;
   localparam int AW = `UDP_REG_ADDR_WIDTH;
   localparam int RW = `CPCI_NF2_DATA_WIDTH;
   localparam logic [AW-3:0] TAG = 21'h1A0000;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic [CW-1:0] in_ctrl = '0;
   logic          in_wr = 1'b0;
   logic          in_rdy;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic          out_wr;
   logic          out_rdy = 1'b0;
   logic          reg_req_in = 1'b0, reg_ack_in = 1'b0, reg_rd_wr_L_in = 1'b0;
   logic [AW-1:0] reg_addr_in = '0;
   logic [RW-1:0] reg_data_in = '0;
   logic [SW-1:0] reg_src_in = '0;
   logic          reg_req_out, reg_ack_out, reg_rd_wr_L_out;
   logic [AW-1:0] reg_addr_out;
   logic [RW-1:0] reg_data_out;
   logic [SW-1:0] reg_src_out;

   crypto_out_stats dut (
      .clk(clk), .reset(reset),
      .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
      .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
      .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
      .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
      .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
      .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [CW-1:0] c; logic [DW-1:0] d; } word_t;
   typedef struct {
      logic req, ack, rdwr;
      logic [AW-1:0] addr;
      logic [RW-1:0] data;
      logic [SW-1:0] src;
   } regx_t;

   word_t exp_q[$];
   regx_t reg_q[$];
   int    checks = 0;
   int    errors = 0;
   bit    rand_rdy = 1'b0;

   // packet-level reference model of the statistics
   logic [31:0] m_pkt = 0, m_word = 0, m_max = 0;
   bit          m_en = 1'b1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      word_t w;
      regx_t e;
      if (out_wr === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out_wr data=%0h ctrl=%0h at %0t", out_data, out_ctrl, $time);
         end else begin
            w = exp_q.pop_front();
            check("out_data", out_data, w.d);
            check("out_ctrl", out_ctrl, w.c);
         end
      end
      if (reg_req_out === 1'b1) begin
         if (reg_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_reg_req_out addr=%0h at %0t", reg_addr_out, $time);
         end else begin
            e = reg_q.pop_front();
            check("reg_ack_out", reg_ack_out, e.ack);
            check("reg_rd_wr_L_out", reg_rd_wr_L_out, e.rdwr);
            check("reg_addr_out", reg_addr_out, e.addr);
            check("reg_src_out", reg_src_out, e.src);
            check("reg_data_out", reg_data_out, e.data);
         end
      end
   end

   task automatic send_word(input logic [CW-1:0] c, input logic [DW-1:0] d);
      bit acc;
      int guard;
      guard = 0;
      in_data = d; in_ctrl = c; in_wr = 1'b1;
      do begin
         if (rand_rdy) out_rdy = ($urandom_range(0, 3) != 0);
         acc = in_rdy;
         if (acc) exp_q.push_back({c, d});
         @(posedge clk); #1;
         guard++;
      end while (!acc && guard < 500);
      in_wr = 1'b0;
      if (!acc) begin
         checks++; errors++;
         $display("FAIL send_timeout in_rdy stayed %0b required 1", in_rdy);
      end
   endtask

   task automatic send_packet(input int h, input int p, input bit rnd);
      int len;
      len = h + p + 1;
      for (int i = 0; i < h; i++)
         send_word(rnd ? CW'($urandom_range(1, 255)) : 8'hFF, {$urandom, $urandom});
      for (int i = 0; i < p; i++)
         send_word(8'h00, {$urandom, $urandom});
      send_word(rnd ? CW'($urandom_range(1, 255)) : 8'h01, {$urandom, $urandom});
      if (m_en) begin
         m_pkt++;
         m_word += 32'(len);
         if (32'(len) > m_max) m_max = 32'(len);
      end
      if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      rand_rdy = 1'b0;
      out_rdy = 1'b1;
      while (exp_q.size() != 0 && guard < 500) begin
         @(posedge clk); #1;
         guard++;
      end
      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout pending=%0d required 0", exp_q.size());
      end
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic reg_access(input bit rd, input logic [AW-1:0] addr, input logic [RW-1:0] wdata,
                             input bit ack_in, input bit exp_ack, input logic [RW-1:0] exp_data);
      regx_t e;
      logic [SW-1:0] src;
      src = SW'($urandom);
      e.req = 1'b1; e.ack = exp_ack; e.rdwr = rd; e.addr = addr; e.data = exp_data; e.src = src;
      reg_q.push_back(e);
      reg_req_in = 1'b1; reg_ack_in = ack_in; reg_rd_wr_L_in = rd;
      reg_addr_in = addr; reg_data_in = wdata; reg_src_in = src;
      @(posedge clk); #1;
      reg_req_in = 1'b0; reg_ack_in = 1'b0;
   endtask

   task automatic reg_read(input logic [1:0] off, input logic [RW-1:0] exp);
      reg_access(1'b1, {TAG, off}, RW'($urandom), 1'b0, 1'b1, exp);
   endtask

   task automatic reg_write(input logic [1:0] off, input logic [RW-1:0] data);
      reg_access(1'b0, {TAG, off}, data, 1'b0, 1'b1, data);
   endtask

   task automatic read_stats();
      reg_read(2'd1, m_pkt);
      reg_read(2'd2, m_word);
      reg_read(2'd3, m_max);
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [RW-1:0] wd;
      // reset state
      #3;
      check("rst_in_rdy", in_rdy, 0);
      check("rst_out_wr", out_wr, 0);
      check("rst_reg_req_out", reg_req_out, 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      check("in_rdy_after_reset", in_rdy, 1);
      reg_read(2'd0, 32'h1);
      read_stats();

      // single 5-word packet, first word out one cycle after its write
      out_rdy = 1'b1;
      check("idle_out_wr", out_wr, 0);
      send_word(8'hFF, 64'h1111_0000_0000_0001);
      check("first_out_latency", out_wr, 1);
      for (int i = 0; i < 3; i++) send_word(8'h00, {32'h2222_0000, 32'(i)});
      send_word(8'h01, 64'h5555_0000_0000_0005);
      m_pkt = 1; m_word = 5; m_max = 5;
      drain();
      read_stats();

      // backpressure: FIFO fills, excess write is dropped, drains in order
      out_rdy = 1'b0;
      send_word(8'hFF, 64'hA0);
      for (int i = 1; i < 4; i++) send_word(8'h00, 64'hA0 + 64'(i));
      check("full_in_rdy", in_rdy, 0);
      check("blocked_out_wr", out_wr, 0);
      in_wr = 1'b1; in_data = 64'hDEAD_BEEF; in_ctrl = 8'hAA;
      @(posedge clk); #1;
      in_wr = 1'b0;
      check("full_stays_full", in_rdy, 0);
      out_rdy = 1'b1;
      @(posedge clk); #1;
      check("rdy_return", in_rdy, 1);
      send_word(8'h01, 64'hA4);
      m_pkt += 1; m_word += 5;
      drain();
      read_stats();

      // clear then 3/8/4-word packets
      reg_write(2'd0, 32'h2);
      m_pkt = 0; m_word = 0; m_max = 0;
      rand_rdy = 1'b1;
      send_packet(1, 1, 1'b0);
      send_packet(2, 5, 1'b0);
      send_packet(1, 2, 1'b0);
      drain();
      read_stats();

      // counting disabled
      reg_write(2'd0, 32'h0);
      m_en = 1'b0;
      reg_read(2'd0, 32'h0);
      send_packet(0, 2, 1'b1);
      drain();
      read_stats();
      reg_write(2'd0, 32'h1);
      m_en = 1'b1;

      // clear coinciding with the EOP word leaving the FIFO
      out_rdy = 1'b0;
      send_word(8'hFF, 64'hC0);
      send_word(8'h00, 64'hC1);
      send_word(8'h01, 64'hC2);
      out_rdy = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reg_write(2'd0, 32'h2);
      m_pkt = 0; m_word = 0; m_max = 0;
      drain();
      read_stats();
      reg_read(2'd0, 32'h1);

      // pass-through: non-matching address and already-acked requests
      send_packet(0, 1, 1'b0);
      drain();
      wd = RW'($urandom);
      reg_access(1'b1, {TAG ^ 21'h1, 2'd1}, wd, 1'b0, 1'b0, wd);
      wd = RW'($urandom);
      reg_access(1'b1, {TAG, 2'd1}, wd, 1'b1, 1'b1, wd);
      reg_access(1'b0, {TAG, 2'd0}, 32'h2, 1'b1, 1'b1, 32'h2);
      reg_read(2'd0, 32'h1);
      read_stats();

      // randomized traffic
      rand_rdy = 1'b1;
      for (int n = 0; n < 25; n++)
         send_packet(int'($urandom_range(0, 2)), int'($urandom_range(1, 6)), 1'b1);
      drain();
      read_stats();

      // reset in the middle of a packet
      out_rdy = 1'b1;
      send_word(8'hFF, 64'hE0);
      send_word(8'h00, 64'hE1);
      drain();
      out_rdy = 1'b0;
      send_word(8'h00, 64'hE2);
      send_word(8'h00, 64'hE3);
      reset = 1'b0;
      exp_q.delete();
      m_pkt = 0; m_word = 0; m_max = 0; m_en = 1'b1;
      #2;
      check("midrst_out_wr", out_wr, 0);
      check("midrst_in_rdy", in_rdy, 0);
      out_rdy = 1'b1;
      @(posedge clk); #1;
      check("midrst_flushed", out_wr, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      check("post_rst_in_rdy", in_rdy, 1);
      check("post_rst_empty", out_wr, 0);
      send_packet(1, 1, 1'b0);
      drain();
      read_stats();
      reg_read(2'd0, 32'h1);

      repeat (3) begin @(posedge clk); #1; end
      check("exp_q_empty", exp_q.size(), 0);
      check("reg_q_empty", reg_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/crypto_out_stats.md
Name: crypto_out_stats

Overview:
- Datapath stage directly downstream of the crypto stage in the user data path.
- Buffers crypto's out_* stream in a small FIFO and re-emits it unchanged toward the output queues.
- Counts packets, counts words and tracks the longest packet.
- Exposes control and counters on the UDP register chain; all other register requests pass through.

Parameters:
- DATA_WIDTH, 64, datapath data width.
- CTRL_WIDTH, 8, datapath ctrl width (DATA_WIDTH/8).
- UDP_REG_SRC_WIDTH, 2, register source tag width.
- FIFO_DEPTH_BITS, 2, log2 of FIFO depth (default 4 words).
- BLOCK_TAG, 21'h1A0000, value of reg_addr[UDP_REG_ADDR_WIDTH-1:2] decoded by this block.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- in_data  in  DATA_WIDTH  data from crypto out_data
- in_ctrl  in  CTRL_WIDTH  ctrl from crypto out_ctrl
- in_wr  in  1  write strobe from crypto out_wr
- in_rdy  out  1  to crypto out_rdy; high when FIFO not full
- out_data  out  DATA_WIDTH  data to output queues
- out_ctrl  out  CTRL_WIDTH  ctrl to output queues
- out_wr  out  1  write strobe to output queues
- out_rdy  in  1  downstream ready
- reg_req_in, reg_ack_in, reg_rd_wr_L_in  in  1 each  register chain inputs
- reg_addr_in  in  `UDP_REG_ADDR_WIDTH  register address
- reg_data_in  in  `CPCI_NF2_DATA_WIDTH  register data
- reg_src_in  in  UDP_REG_SRC_WIDTH  register source
- reg_req_out, reg_ack_out, reg_rd_wr_L_out  out  1 each  register chain outputs
- reg_addr_out, reg_data_out, reg_src_out  out  same widths as inputs  register chain outputs

Behaviour:
- Reset (reset=0, async):
  - All outputs 0, except in_rdy=1 once reset deasserts.
  - FIFO empty; counters 0; CTRL=0x1 (enable).
  - FSM in S_HDR.
- FIFO:
  - Write when in_wr && in_rdy. in_wr while full is a protocol violation; the word is dropped and the FIFO is not corrupted.
  - in_rdy = (count < depth), registered view of count.
  - out_wr=1 for exactly one cycle per word when FIFO non-empty and out_rdy=1; out_data/out_ctrl are valid in that cycle.
  - Latency: a word written in cycle N can appear on out_* no earlier than cycle N+1.
  - Simultaneous read and write when full or empty: count stays correct; no bubble when full.
  - Order preserved exactly; data and ctrl are unmodified.
- Packet framing FSM, advanced on each out_wr:
  - S_HDR: ctrl!=0 words are module headers. The first ctrl==0 word moves to S_PAYLOAD.
  - S_PAYLOAD: ctrl==0 words stay in S_PAYLOAD. A ctrl!=0 word is EOP and returns to S_HDR.
  - cur_len counts all words of the current packet, including headers and EOP. It resets to 0 after EOP.
- Counters (32-bit, wrap 0xFFFFFFFF->0, update only when CTRL[0]=1):
  - WORD_CNT +1 per out_wr.
  - PKT_CNT +1 per EOP.
  - MAX_LEN = max(MAX_LEN, final cur_len) at EOP.
- Registers (match when reg_addr_in[top:2]==BLOCK_TAG, offset = reg_addr_in[1:0]):
  - 0: CTRL, RW. Bit0 = enable, bit1 = clear, self-clearing and reading back as 0.
  - 1: PKT_CNT, RO.
  - 2: WORD_CNT, RO.
  - 3: MAX_LEN, RO.
  - Writes to RO registers are acked and ignored.
  - Clear in the same cycle as an increment: clear wins; the counter reads 0.
- Register chain (1-cycle registered pass):
  - If reg_req_in && !reg_ack_in && address match: next cycle reg_ack_out=1. For reads, reg_data_out = register value; for writes, reg_data_out = reg_data_in and the write takes effect. req/addr/src/rd_wr_L are forwarded.
  - Otherwise all reg_*_out = reg_*_in delayed one cycle, including a request already acked upstream.
  - reg_req_out is never asserted for more cycles than reg_req_in.
- Reset mid-packet:
  - FIFO is flushed and the FSM returns to S_HDR.
  - Partial words already emitted are not recalled; resynchronisation is the upstream's job.

Test Plan:
1. Reset, then a 5-word packet: ctrl FF, 00, 00, 00, 01, out_rdy=1 -> same 5 words out in order, first out_wr at +1 cycle; PKT_CNT=1, WORD_CNT=5, MAX_LEN=5.
2. out_rdy=0, write 5 words -> in_rdy drops after 4th write, out_wr stays 0. Raise out_rdy -> in_rdy returns high next cycle, all words drain, no loss.
3. Packets of 3 then 8 then 4 words -> PKT_CNT=3, WORD_CNT=15, MAX_LEN=8.
4. Write CTRL=0x2 in the same cycle as an EOP out_wr -> all counters read 0; CTRL reads 0x1.
5. Register read to a non-matching address, and a matching request with reg_ack_in=1 -> both forwarded unchanged one cycle later; no state change.
6. Assert reset after 2 of 6 words are in the FIFO -> out_wr=0, FIFO empty, counters 0. A new 3-word packet is then counted as PKT_CNT=1.
